// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg / mem_port_arbiter_if
// Description : Shared types and the requester/memory bus bundle for the
//               fetch/load-store memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;
    typedef logic [31:0] cpu_word;
    typedef logic [1:0]  mem_mode;

    localparam mem_mode MEM_W = 2'd0;
    localparam mem_mode MEM_H = 2'd1;
    localparam mem_mode MEM_B = 2'd2;
endpackage

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_port_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    cpu_word           if_rdata;

    logic              ls_req;
    logic              ls_we;
    mem_mode           ls_mode;
    logic [ADDR_W-1:0] ls_addr;
    cpu_word           ls_wdata;
    logic              ls_ack;
    cpu_word           ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    cpu_word           mem_wdata;
    cpu_word           mem_rdata;
    logic              mem_ready;

    // master: the arbiter itself; slave: requesters plus memory around it
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_mode, ls_addr, ls_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, if_rdata, ls_ack, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_mode, ls_addr, ls_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, if_rdata, ls_ack, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one word-wide memory port between instruction fetch
//               and load/store, with sub-word loads and read-modify-write
//               sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        STORE  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t            r_state;
    logic              r_last_ls;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    cpu_word           r_mem_wdata;
    logic              r_if_ack;
    logic              r_ls_ack;
    cpu_word           r_if_rdata;
    cpu_word           r_ls_rdata;

    logic w_contest;
    logic w_grant_ls;
    logic w_grant_if;
    logic w_ls_sub;
    logic w_unused_bits;

    // On contention the requester that did not win last time goes first
    assign w_contest     = bus.if_req && bus.ls_req;
    assign w_grant_ls    = bus.ls_req && (!bus.if_req || !r_last_ls);
    assign w_grant_if    = bus.if_req && !w_grant_ls;
    assign w_ls_sub      = (bus.ls_mode == MEM_H) || (bus.ls_mode == MEM_B);
    assign w_unused_bits = &{1'b0, bus.if_addr[1:0]};

    function automatic cpu_word extract_lane(input cpu_word w, input logic [1:0] lane,
                                             input mem_mode mode);
        cpu_word res;
        res = w;
        case (mode)
            MEM_H: res = lane[1] ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
            MEM_B: begin
                case (lane)
                    2'd0:    res = {24'h000000, w[7:0]};
                    2'd1:    res = {24'h000000, w[15:8]};
                    2'd2:    res = {24'h000000, w[23:16]};
                    default: res = {24'h000000, w[31:24]};
                endcase
            end
            default: res = w;
        endcase
        return res;
    endfunction

    function automatic cpu_word merge_lane(input cpu_word w, input cpu_word wd,
                                           input logic [1:0] lane, input mem_mode mode);
        cpu_word res;
        res = wd;
        case (mode)
            MEM_H: res = lane[1] ? {wd[15:0], w[15:0]} : {w[31:16], wd[15:0]};
            MEM_B: begin
                case (lane)
                    2'd0:    res = {w[31:8], wd[7:0]};
                    2'd1:    res = {w[31:16], wd[7:0], w[7:0]};
                    2'd2:    res = {w[31:24], wd[7:0], w[15:0]};
                    default: res = {wd[7:0], w[23:0]};
                endcase
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_ls   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_ls) begin
                        if (w_contest) r_last_ls <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= {bus.ls_addr[ADDR_W-1:2], 2'b00};
                        if (bus.ls_we && !w_ls_sub) begin
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= bus.ls_wdata;
                            r_state     <= STORE;
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= bus.ls_we ? RMW_RD : LOAD;
                        end
                    end else if (w_grant_if) begin
                        if (w_contest) r_last_ls <= 1'b0;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        r_if_rdata <= bus.mem_rdata;
                        r_mem_en   <= 1'b0;
                        r_if_ack   <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                LOAD: begin
                    if (bus.mem_ready) begin
                        r_ls_rdata <= extract_lane(bus.mem_rdata, bus.ls_addr[1:0], bus.ls_mode);
                        r_mem_en   <= 1'b0;
                        r_ls_ack   <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                RMW_RD: begin
                    // mem_en stays high: the write phase follows back to back
                    if (bus.mem_ready) begin
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= merge_lane(bus.mem_rdata, bus.ls_wdata,
                                                  bus.ls_addr[1:0], bus.ls_mode);
                        r_state     <= RMW_WR;
                    end
                end
                RMW_WR, STORE: begin
                    if (bus.mem_ready) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_ls_ack <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_if_ack <= 1'b0;
                    r_ls_ack <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.ls_ack    = r_ls_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_rdata  = r_ls_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    int stab_bad = 0;
    int overlap = 0;
    int wrong_ack = 0;
    logic [31:0] mem [256];
    logic [31:0] model_mem [16];
    logic [31:0] last_acc_addr = 32'h0;
    logic        p_en = 1'b0, p_done = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_wd = 32'h0;

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        int          waits;
        logic [31:0] exp_rd;
        logic [31:0] exp_mem;
        int          exp_lat;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers after wait_cfg wait cycles per access
    always @(negedge clk) begin
        if (bus.mem_en && wcnt >= wait_cfg) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[9:2]];
        end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'h0;
        end
        if (bus.if_ack && bus.ls_ack) overlap++;
    end

    always @(posedge clk) begin
        if (bus.mem_en && p_en && !p_done &&
            (bus.mem_addr !== p_addr || bus.mem_we !== p_we || bus.mem_wdata !== p_wd))
            stab_bad++;
        if (bus.mem_en && bus.mem_ready) begin
            if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            last_acc_addr = bus.mem_addr;
            wcnt = 0;
        end else if (bus.mem_en) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
        p_en   = bus.mem_en;
        p_done = bus.mem_ready;
        p_addr = bus.mem_addr;
        p_we   = bus.mem_we;
        p_wd   = bus.mem_wdata;
    end

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] mode);
        int sh;
        if (mode == MEM_H) begin
            sh = 16 * int'(a[1]);
            return (w >> sh) & 32'h0000FFFF;
        end else if (mode == MEM_B) begin
            sh = 8 * int'(a[1:0]);
            return (w >> sh) & 32'h000000FF;
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] mode, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        if (mode == MEM_H) begin
            sh = 16 * int'(a[1]);
            mask = 32'h0000FFFF << sh;
        end else if (mode == MEM_B) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'h000000FF << sh;
        end else begin
            return wd;
        end
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // Starts at a negedge with the arbiter idle; returns one cycle after the ack
    task automatic run_txn(input bit is_ls, input bit we, input logic [1:0] mode,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        bit got = 1'b0;
        lat = 0;
        rd = 32'h0;
        if (is_ls) begin
            bus.ls_we = we; bus.ls_mode = mode; bus.ls_addr = addr;
            bus.ls_wdata = wd; bus.ls_req = 1'b1;
        end else begin
            bus.if_addr = addr; bus.if_req = 1'b1;
        end
        while (!got && lat < 80) begin
            @(negedge clk);
            lat++;
            if (is_ls ? bus.if_ack : bus.ls_ack) wrong_ack++;
            if (is_ls ? bus.ls_ack : bus.if_ack) begin
                got = 1'b1;
                rd = is_ls ? bus.ls_rdata : bus.if_rdata;
            end
        end
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
        chk("ack_seen", {31'b0, got}, 32'h1);
        @(negedge clk);
        chk("ack_one_cycle", {31'b0, bus.if_ack | bus.ls_ack}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd, prev_ls, word, exp_rd;
        int lat, exp_lat, n, order[4];
        bit is_ls, we, seen;
        logic [1:0] mode;
        logic [31:0] addr, wd;

        vt[0]  = '{0, 0, MEM_W, 32'h104, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0, 2};
        vt[1]  = '{1, 0, MEM_B, 32'h13,  32'h0,        32'hAABBCCDD, 0, 32'h000000AA, 32'h0, 2};
        vt[2]  = '{1, 0, MEM_H, 32'h12,  32'h0,        32'hAABBCCDD, 0, 32'h0000AABB, 32'h0, 2};
        vt[3]  = '{1, 0, MEM_H, 32'h11,  32'h0,        32'hAABBCCDD, 0, 32'h0000CCDD, 32'h0, 2};
        vt[4]  = '{1, 0, MEM_B, 32'h10,  32'h0,        32'hAABBCCDD, 0, 32'h000000DD, 32'h0, 2};
        vt[5]  = '{1, 0, MEM_W, 32'h10,  32'h0,        32'hAABBCCDD, 0, 32'hAABBCCDD, 32'h0, 2};
        vt[6]  = '{1, 0, 2'd3,  32'h12,  32'h0,        32'hAABBCCDD, 0, 32'hAABBCCDD, 32'h0, 2};
        vt[7]  = '{1, 1, MEM_B, 32'h21,  32'h55,       32'h11223344, 0, 32'h0, 32'h11225544, 3};
        vt[8]  = '{1, 1, MEM_H, 32'h22,  32'h9999ABCD, 32'h11223344, 0, 32'h0, 32'hABCD3344, 3};
        vt[9]  = '{1, 1, MEM_W, 32'h24,  32'hCAFEF00D, 32'h0,        0, 32'h0, 32'hCAFEF00D, 2};
        vt[10] = '{1, 0, MEM_B, 32'h13,  32'h0,        32'hAABBCCDD, 3, 32'h000000AA, 32'h0, 5};
        vt[11] = '{1, 1, MEM_B, 32'h23,  32'hFFFFFF77, 32'h11223344, 2, 32'h0, 32'h77223344, 7};
        vt[12] = '{0, 0, MEM_W, 32'h106, 32'h0,        32'h01234567, 1, 32'h01234567, 32'h0, 3};

        for (int k = 0; k < 256; k++) mem[k] = 32'h0;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_mode = MEM_W;
        bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_mem_en",    {31'b0, bus.mem_en}, 32'h0);
        chk("rst_mem_we",    {31'b0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_acks",      {30'b0, bus.if_ack, bus.ls_ack}, 32'h0);
        chk("rst_if_rdata",  bus.if_rdata, 32'h0);
        chk("rst_ls_rdata",  bus.ls_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Contention with both requests held: LS first, then alternating
        wait_cfg = 0;
        mem[65] = 32'h0F0F0F0F;
        mem[4]  = 32'h12345678;
        bus.if_addr = 32'h104;
        bus.ls_we = 1'b0; bus.ls_mode = MEM_W; bus.ls_addr = 32'h10;
        bus.if_req = 1'b1; bus.ls_req = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.ls_ack && !bus.if_ack) begin order[n] = 1; n++; end
            else if (bus.if_ack && !bus.ls_ack) begin order[n] = 0; n++; end
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        @(negedge clk);
        chk("contest_count", n, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("contest_grant%0d", k), (k < n) ? order[k] : -1, (k % 2 == 0) ? 1 : 0);

        // Directed vectors
        foreach (vt[i]) begin
            wait_cfg = vt[i].waits;
            mem[vt[i].addr[9:2]] = vt[i].pre;
            prev_ls = bus.ls_rdata;
            run_txn(vt[i].is_ls, vt[i].we, vt[i].mode, vt[i].addr, vt[i].wdata, rd, lat);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_mem_addr", i), last_acc_addr, vt[i].addr & 32'hFFFFFFFC);
            if (vt[i].is_ls && vt[i].we) begin
                chk($sformatf("vec%0d_mem_word", i), mem[vt[i].addr[9:2]], vt[i].exp_mem);
                chk($sformatf("vec%0d_ls_rdata_kept", i), bus.ls_rdata, prev_ls);
            end else begin
                chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            end
        end

        // Reset while the RMW write phase is waiting on memory
        wait_cfg = 2;
        mem[12] = 32'h11223344;
        bus.ls_we = 1'b1; bus.ls_mode = MEM_B; bus.ls_addr = 32'h31;
        bus.ls_wdata = 32'h66; bus.ls_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (bus.mem_en && bus.mem_we) seen = 1'b1;
        end
        chk("rmw_wr_reached", {31'b0, seen}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_en", {31'b0, bus.mem_en}, 32'h0);
        chk("rst_mid_ls_ack", {31'b0, bus.ls_ack}, 32'h0);
        rst = 1'b0;
        bus.ls_req = 1'b0;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ls_ack || bus.mem_en) n++;
        end
        chk("rst_mid_quiet", n, 0);
        chk("rst_mid_mem_untouched", mem[12], 32'h11223344);
        wait_cfg = 0;
        run_txn(1, 0, MEM_W, 32'h30, 32'h0, rd, lat);
        chk("after_rst_rdata", rd, 32'h11223344);
        chk("after_rst_latency", lat, 2);

        // Randomized single-requester traffic against a shadow memory
        for (int k = 0; k < 16; k++) begin
            model_mem[k] = $urandom;
            mem[k] = model_mem[k];
        end
        for (int t = 0; t < 40; t++) begin
            is_ls = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 3));
            addr  = 32'($urandom_range(0, 63));
            wd    = $urandom;
            wait_cfg = $urandom_range(0, 2);
            word = model_mem[addr[5:2]];
            exp_rd = 32'h0;
            exp_lat = 2 + wait_cfg;
            if (!is_ls) begin
                exp_rd = word;
            end else if (!we) begin
                exp_rd = model_load(word, addr, mode);
            end else begin
                model_mem[addr[5:2]] = model_store(word, addr, mode, wd);
                if (mode == MEM_H || mode == MEM_B) exp_lat = 3 + 2 * wait_cfg;
            end
            run_txn(is_ls, we, mode, addr, wd, rd, lat);
            chk($sformatf("rand%0d_latency", t), lat, exp_lat);
            if (!(is_ls && we)) chk($sformatf("rand%0d_rdata", t), rd, exp_rd);
        end
        for (int k = 0; k < 16; k++)
            chk($sformatf("rand_mem%0d", k), mem[k], model_mem[k]);

        chk("ack_overlap", overlap, 0);
        chk("wrong_ack", wrong_ack, 0);
        chk("mem_stable", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
